// File: rtl/alu16_sched_pkg.sv
// alu16_sched_pkg
// Shared types and constants for the alu16_sched ALU sequencer:
//   - state_t    : sequencer FSM states
//   - ALU_*      : 3-bit sel codes understood by the external ALU
//   - OP_MUL_BIT : request opcode bit that selects the shift-add multiply
//   - MUL_STEPS  : number of shift-add iterations for a 16-bit multiply
//   - W          : datapath width (fixed at 16 to match the ALU)

package alu16_sched_pkg;

    localparam int W          = 16;
    localparam int OP_MUL_BIT = 3;
    localparam int MUL_STEPS  = 16;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu16_sched_if.sv
// alu16_sched_if
// Request/response bundle between the two requesters, the response consumer
// and the alu16_sched sequencer.
//   req0_* / req1_* : valid/ready request channels carrying a, b and op
//   rsp_*           : single valid/ready response channel with id, data, err
// Modports:
//   master : requester/consumer side (drives requests, accepts responses)
//   slave  : sequencer side

interface alu16_sched_if;
    import alu16_sched_pkg::*;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [3:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [3:0]   req1_op;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu16_rr_arb2.sv
// alu16_rr_arb2
// Two-request round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   valid0/1   : request present on each port
//   enable     : grants may be issued this cycle (sequencer idle)
//   accept     : the current grant is being taken; updates the pointer
//   grant      : one-hot grant, bit i for port i, zero when nothing granted

module alu16_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    // Under contention the port that was not granted last wins; a lone
    // request always wins. The pointer starts at 1 so req0 wins first.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid0 && valid1) begin
                grant = last ? 2'b01 : 2'b10;
            end else if (valid0) begin
                grant = 2'b01;
            end else if (valid1) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/alu16_sched.sv
// alu16_sched
// Sequencer and two-port round-robin arbiter in front of a shared
// combinational 16-bit ALU. One request is accepted at a time, executed on the
// external ALU and returned on the response channel tagged with its port id.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   bus (slave)       : req0/req1 request channels and the response channel
//   busy              : sequencer is not idle
//   alu_a/alu_b/alu_sel : operands and sel code driven to the external ALU
//   alu_out           : combinational result from the external ALU
// Configuration:
//   ALU16_SCHED_MUL_EN : when defined, op[3]=1 runs a 16-step shift-add
//                        multiply on the ALU's ADD path; when undefined,
//                        op[3]=1 returns data 0 with rsp_err set.

module alu16_sched
    import alu16_sched_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    alu16_sched_if.slave  bus,
    output logic          busy,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_sel,
    input  logic [W-1:0]  alu_out
);

    state_t       state;
    state_t       state_next;

    logic [1:0]   grant;
    logic         accept;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_op;
    logic         take_mul;

    logic [W-1:0] lat_a;
    logic [W-1:0] lat_b;
    logic [3:0]   lat_op;
    logic         lat_id;
    logic [W-1:0] rsp_data_q;
    logic         rsp_err_q;

`ifdef ALU16_SCHED_MUL_EN
    logic [W-1:0] acc;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [3:0]   step;
    logic         last_step;

    assign last_step = (step == 4'(MUL_STEPS - 1));
`endif

    alu16_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .enable (state == IDLE),
        .accept (accept),
        .grant  (grant)
    );

    // A grant is only issued to a valid request, so any grant is an accept.
    assign accept = |grant;
    assign in_a   = grant[1] ? bus.req1_a  : bus.req0_a;
    assign in_b   = grant[1] ? bus.req1_b  : bus.req0_b;
    assign in_op  = grant[1] ? bus.req1_op : bus.req0_op;

`ifdef ALU16_SCHED_MUL_EN
    assign take_mul = in_op[OP_MUL_BIT];
`else
    assign take_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // No request is taken in RESP, so the response handshake and the next
    // accept never share a cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = take_mul ? MUL : EXEC;
                end
            end
            EXEC: state_next = RESP;
`ifdef ALU16_SCHED_MUL_EN
            MUL: begin
                if (last_step) begin
                    state_next = RESP;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response fields are gated by RESP so every output reads 0 outside a
    // pending response, including straight after reset.
    always_comb begin
        alu_a          = '0;
        alu_b          = '0;
        alu_sel        = ALU_AND;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_id     = 1'b0;
        bus.rsp_data   = '0;
        bus.rsp_err    = 1'b0;
        busy           = (state != IDLE);
        unique case (state)
            IDLE: begin
                bus.req0_ready = grant[0];
                bus.req1_ready = grant[1];
            end
            EXEC: begin
                alu_a   = lat_a;
                alu_b   = lat_b;
                alu_sel = lat_op[2:0];
            end
`ifdef ALU16_SCHED_MUL_EN
            MUL: begin
                alu_a   = acc;
                alu_b   = mcand;
                alu_sel = ALU_ADD;
            end
`endif
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = lat_id;
                bus.rsp_data  = rsp_data_q;
                bus.rsp_err   = rsp_err_q;
            end
            default: ;
        endcase
    end

    // Request latch and result capture. A MUL-flagged op only reaches EXEC
    // when the multiplier is not built, so it is answered as an error there.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_id     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lat_a  <= in_a;
                        lat_b  <= in_b;
                        lat_op <= in_op;
                        lat_id <= grant[1];
                    end
                end
                EXEC: begin
                    if (lat_op[OP_MUL_BIT]) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        rsp_data_q <= alu_out;
                        rsp_err_q  <= 1'b0;
                    end
                end
`ifdef ALU16_SCHED_MUL_EN
                MUL: begin
                    if (last_step) begin
                        rsp_data_q <= mplier[0] ? alu_out : acc;
                        rsp_err_q  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef ALU16_SCHED_MUL_EN
    // Shift-add multiply: the ALU adds mcand into acc whenever the current
    // multiplier LSB is set; mcand walks left and mplier walks right.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            step   <= '0;
        end else if (state == IDLE && accept) begin
            acc    <= '0;
            mcand  <= in_a;
            mplier <= in_b;
            step   <= '0;
        end else if (state == MUL) begin
            if (mplier[0]) begin
                acc <= alu_out;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu16_sched.sv
// tb_alu16_sched
// Self-checking bench for alu16_sched with a behavioural ALU attached to the
// alu_* ports. Expected responses are queued when requests are issued and
// popped when the response appears. Covers both builds of ALU16_SCHED_MUL_EN.

module tb_alu16_sched;
    import alu16_sched_pkg::*;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    alu16_sched_if bus ();

    alu16_sched dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_out (alu_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] sel);
        case (sel)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_model(alu_a, alu_b, alu_sel);

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raises valid on one port and returns the cycle it was accepted in
    // (-1 if never). Returns at the negedge after the accept, with valid low
    // and the operand inputs scrambled.
    task automatic issue(input bit port, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, output int acc_cyc);
        acc_cyc = -1;
        @(negedge clk);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (port) begin
            bus.req1_valid = 1'b0; bus.req1_a = ~a; bus.req1_b = ~b; bus.req1_op = 4'b0001;
        end else begin
            bus.req0_valid = 1'b0; bus.req0_a = ~a; bus.req0_b = ~b; bus.req0_op = 4'b0001;
        end
    endtask

    // Waits (bounded) at negedges for rsp_valid and samples the response.
    task automatic wait_rsp(output int rcyc, output logic id, output logic [15:0] data,
                            output logic err);
        rcyc = -1; id = 1'b0; data = '0; err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                rcyc = cyc; id = bus.rsp_id; data = bus.rsp_data; err = bus.rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req0_ready,
             bus.req1_ready, alu_a, alu_b, alu_sel} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got valid=%b id=%b data=%h err=%b rdy=%b%b a=%h b=%h sel=%b, expected all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req0_ready,
                     bus.req1_ready, alu_a, alu_b, alu_sel);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int ac, rc; logic rid, rerr; logic [15:0] rdata; exp_t e;
        sb.push_back('{id: 1'b0, data: 16'h2233, err: 1'b0});
        issue(1'b0, 16'h1234, 16'h0FFF, 4'b0010, ac);
        tests_run++;
        if ({busy, bus.rsp_valid, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 16'h1234, 16'h0FFF, ALU_ADD}) begin
            tests_failed++;
            $display("[TB] FAIL single_exec: got busy=%b rv=%b a=%h b=%h sel=%b, expected 1 0 1234 0fff 010",
                     busy, bus.rsp_valid, alu_a, alu_b, alu_sel);
        end
        wait_rsp(rc, rid, rdata, rerr);
        tests_run++;
        if (rc - ac !== 2 || ac < 0) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got %0d, expected 2", rc - ac);
        end
        e = sb.pop_front();
        tests_run++;
        if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL single_rsp: got id=%b data=%h err=%b, expected id=%b data=%h err=%b",
                     rid, rdata, rerr, e.id, e.data, e.err);
        end
        @(negedge clk);
        tests_run++;
        if ({busy, bus.rsp_valid} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL single_idle: got busy=%b rv=%b, expected 0 0", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        int rc, prev; logic rid, rerr; logic [15:0] rdata; exp_t e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{id: 1'b0, data: 16'hFFFE, err: 1'b0});
            sb.push_back('{id: 1'b1, data: 16'h0001, err: 1'b0});
        end
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 16'd5; bus.req0_b = 16'd7; bus.req0_op = 4'b0110;
        bus.req1_valid = 1'b1; bus.req1_a = 16'd3; bus.req1_b = 16'd9; bus.req1_op = 4'b0111;
        #1;
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL contention_first_grant: got rdy0=%b rdy1=%b, expected 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        prev = -1;
        for (int n = 0; n < 4; n++) begin
            wait_rsp(rc, rid, rdata, rerr);
            e = sb.pop_front();
            tests_run++;
            if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL contention_rsp%0d: got id=%b data=%h err=%b, expected id=%b data=%h err=%b",
                         n, rid, rdata, rerr, e.id, e.data, e.err);
            end
            tests_run++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL contention_ready_in_resp%0d: got %b%b, expected 00",
                         n, bus.req0_ready, bus.req1_ready);
            end
            if (n > 0) begin
                tests_run++;
                if (rc - prev !== 3 || rc < 0) begin
                    tests_failed++;
                    $display("[TB] FAIL contention_interval%0d: got %0d, expected 3", n, rc - prev);
                end
            end
            prev = rc;
            if (n == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul();
        int ac, rc; logic rid, rerr; logic [15:0] rdata; exp_t e;
`ifdef ALU16_SCHED_MUL_EN
        sb.push_back('{id: 1'b0, data: 16'h4E6F, err: 1'b0});
        issue(1'b0, 16'h0123, 16'h0045, 4'b1010, ac);
        tests_run++;
        if ({alu_sel, alu_a, alu_b} !== {ALU_ADD, 16'h0000, 16'h0123}) begin
            tests_failed++;
            $display("[TB] FAIL mul_first_step: got sel=%b a=%h b=%h, expected 010 0000 0123",
                     alu_sel, alu_a, alu_b);
        end
        wait_rsp(rc, rid, rdata, rerr);
        tests_run++;
        if (rc - ac !== 17 || ac < 0) begin
            tests_failed++;
            $display("[TB] FAIL mul_latency: got %0d, expected 17", rc - ac);
        end
        e = sb.pop_front();
        tests_run++;
        if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL mul_rsp: got id=%b data=%h err=%b, expected id=%b data=%h err=%b",
                     rid, rdata, rerr, e.id, e.data, e.err);
        end
        sb.push_back('{id: 1'b1, data: 16'h0001, err: 1'b0});
        issue(1'b1, 16'hFFFF, 16'hFFFF, 4'b1010, ac);
        wait_rsp(rc, rid, rdata, rerr);
        e = sb.pop_front();
        tests_run++;
        if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL mul_wrap_rsp: got id=%b data=%h err=%b, expected id=%b data=%h err=%b",
                     rid, rdata, rerr, e.id, e.data, e.err);
        end
`else
        sb.push_back('{id: 1'b1, data: 16'h0000, err: 1'b1});
        issue(1'b1, 16'h0123, 16'h0045, 4'b1010, ac);
        wait_rsp(rc, rid, rdata, rerr);
        tests_run++;
        if (rc - ac !== 2 || ac < 0) begin
            tests_failed++;
            $display("[TB] FAIL mul_off_latency: got %0d, expected 2", rc - ac);
        end
        e = sb.pop_front();
        tests_run++;
        if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL mul_off_rsp: got id=%b data=%h err=%b, expected id=%b data=%h err=%b",
                     rid, rdata, rerr, e.id, e.data, e.err);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_random_ops();
        int ac, rc; logic rid, rerr; logic [15:0] rdata, a, b; logic [2:0] sel; bit port;
        exp_t e;
        logic [2:0] sels [5];
        sels = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
        for (int n = 0; n < 6; n++) begin
            port = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            sel  = sels[$urandom_range(0, 4)];
            sb.push_back('{id: port, data: alu_model(a, b, sel), err: 1'b0});
            issue(port, a, b, {1'b0, sel}, ac);
            wait_rsp(rc, rid, rdata, rerr);
            e = sb.pop_front();
            tests_run++;
            if ({rid, rdata, rerr} !== {e.id, e.data, e.err} || rc - ac !== 2) begin
                tests_failed++;
                $display("[TB] FAIL random_op%0d sel=%b a=%h b=%h: got id=%b data=%h err=%b lat=%0d, expected id=%b data=%h err=%b lat=2",
                         n, sel, a, b, rid, rdata, rerr, rc - ac, e.id, e.data, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int ac, rc; logic rid, rerr; logic [15:0] rdata; exp_t e;
        bus.rsp_ready = 1'b0;
        sb.push_back('{id: 1'b1, data: 16'h3030, err: 1'b0});
        issue(1'b1, 16'hF0F0, 16'h3C3C, 4'b0000, ac);
        wait_rsp(rc, rid, rdata, rerr);
        e = sb.pop_front();
        tests_run++;
        if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL bp_rsp: got id=%b data=%h err=%b, expected id=%b data=%h err=%b",
                     rid, rdata, rerr, e.id, e.data, e.err);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready, bus.req1_ready, busy}
                !== {1'b1, e.id, e.data, 1'b0, 1'b0, 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold%0d: got rv=%b id=%b data=%h rdy=%b%b busy=%b, expected 1 1 3030 00 1",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready,
                         bus.req1_ready, busy);
            end
            @(negedge clk);
        end
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, bus.rsp_valid} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: got busy=%b rv=%b, expected 0 0", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_reset_midop();
        int ac, rc; logic rid, rerr; logic [15:0] rdata; exp_t e;
`ifdef ALU16_SCHED_MUL_EN
        issue(1'b0, 16'h0123, 16'h0045, 4'b1010, ac);
        while (cyc < ac + 9) @(negedge clk);
`else
        bus.rsp_ready = 1'b0;
        issue(1'b0, 16'h1111, 16'h2222, 4'b0010, ac);
        wait_rsp(rc, rid, rdata, rerr);
`endif
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req0_ready,
             bus.req1_ready, alu_a, alu_b, alu_sel} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midop_reset: got busy=%b rv=%b id=%b data=%h err=%b rdy=%b%b a=%h b=%h sel=%b, expected all 0",
                     busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
                     bus.req0_ready, bus.req1_ready, alu_a, alu_b, alu_sel);
        end
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        sb.push_back('{id: 1'b1, data: 16'h0FF0, err: 1'b0});
        issue(1'b1, 16'h00F0, 16'h0F00, 4'b0001, ac);
        wait_rsp(rc, rid, rdata, rerr);
        e = sb.pop_front();
        tests_run++;
        if ({rid, rdata, rerr} !== {e.id, e.data, e.err} || rc - ac !== 2) begin
            tests_failed++;
            $display("[TB] FAIL midop_after: got id=%b data=%h err=%b lat=%0d, expected id=%b data=%h err=%b lat=2",
                     rid, rdata, rerr, rc - ac, e.id, e.data, e.err);
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_mul();
        test_random_ops();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu16_sched.md
# alu16_sched

Sequencer and two-port arbiter for the shared combinational 16-bit ALU. Two requesters submit operations over valid/ready handshakes; the block arbitrates round-robin, latches operands and drives the ALU's A/B/sel inputs. It captures the ALU output and returns it with the requester ID on a single response channel. Optionally, it runs a 16-step shift-add multiply by reusing the ALU's ADD path.

## Interface
- W, 16, datapath width; only 16 is supported, to match the ALU.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a / req1_a  in  W  operand A.
- req0_b / req1_b  in  W  operand B.
- req0_op / req1_op  in  4  bit 3 selects MUL; bits [2:0] are the ALU sel code.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  index of the requester being answered.
- rsp_data  out  W  result.
- rsp_err  out  1  unsupported operation.
- busy  out  1  state is not IDLE.
- alu_a, alu_b  out  W  operands to the ALU.
- alu_sel  out  3  ALU sel code.
- alu_out  in  W  combinational ALU result.

## Operation
- ALU sel codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111. Other codes are passed through verbatim; the result is whatever the ALU produces.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - Drive alu_a = 0, alu_b = 0, alu_sel = 000.
  - If one or both requests are valid, grant one and raise only its ready, combinationally, in the same cycle.
  - On acceptance, latch a, b, op and id.
  - Next state is MUL if op[3]=1 and the feature is compiled in; otherwise EXEC.
- Round-robin arbitration:
  - A last-grant pointer is updated on every accept.
  - When both requests are valid, grant the port that is not the pointer.
  - A lone valid request is always granted.
  - The pointer resets to 1, so req0 wins the first contention.
- EXEC:
  - Drive latched a, b and op[2:0] to the ALU.
  - Capture alu_out into rsp_data.
  - Go to RESP.
- MUL:
  - Registers: acc (reset to 0 on entry), mcand = a, mplier = b, and a 4-bit step counter starting at 0.
  - Each cycle drive alu_a = acc, alu_b = mcand, alu_sel = 010.
  - If mplier[0]=1, acc <= alu_out.
  - Every cycle: mcand <= mcand << 1, mplier <= mplier >> 1.
  - After step 15, rsp_data <= the final acc, then go to RESP.
  - Result is the low 16 bits of the product (modulo 2^16); no overflow flag.
- RESP:
  - rsp_valid = 1, with rsp_id, rsp_data and rsp_err held stable.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Requesters must not make valid depend on ready. Once a request is latched, changes to its inputs are ignored.

## Timing
- Reset values: state = IDLE; all outputs 0 (rsp_valid, rsp_id, rsp_data, rsp_err, busy, both readys, alu_a, alu_b, alu_sel); pointer = 1.
- Reset asserted mid-operation aborts the operation. The next cycle shows reset values, and the in-flight response is lost.
- Non-MUL op: accept at cycle T, rsp_valid from T+2. Minimum issue interval is 3 cycles with rsp_ready held high.
- MUL op: accept at T, MUL steps run in cycles T+1 to T+16, rsp_valid from T+17. Minimum interval is 18 cycles.
- Response backpressure: rsp_valid stays high with stable data until accepted. busy stays high for that whole time.

## Configuration
- Macro: ALU16_SCHED_MUL_EN.
- Defined: the MUL state and its registers exist; op[3]=1 runs the multiply and rsp_err = 0.
- Undefined: no MUL logic is built. op[3]=1 takes the EXEC path, but rsp_data = 0 and rsp_err = 1, with non-MUL latency.
- The port list is identical in both builds.

## Structure
- Package alu16_sched_pkg holds:
  - the state enum;
  - the sel code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - the OP_MUL_BIT index (3);
  - the MUL_STEPS constant (16).
- Sub-module alu16_rr_arb2 contains the two-request round-robin grant logic and the last-grant pointer. Inputs: both valids, an enable (IDLE), and accept. Output: a one-hot grant.
- The ALU itself is instantiated outside this block and connected via the alu_* ports.

## Test plan
- Single request: req0 ADD a=0x1234, b=0x0FFF -> rsp_valid at T+2, rsp_id=0, rsp_data=0x2233, rsp_err=0.
- Contention, both valid every cycle: req0 SUB 5-7 and req1 SLT 3<9 -> req0 is granted first (result 0xFFFE), then req1 (result 0x0001). Grants alternate over 4 consecutive requests.
- MUL (macro defined): a=0x0123, b=0x0045 -> rsp_data=0x4E6F at T+17. Also a=0xFFFF, b=0xFFFF -> 0x0001.
- MUL with the macro undefined: op=1010 -> rsp_data=0x0000, rsp_err=1 at T+2.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable, req ready stays 0 for both ports; accepted on the cycle rsp_ready rises, IDLE the next cycle.
- Reset at MUL step 8 -> next cycle all outputs 0 and busy=0; a following req1 OR 0x00F0|0x0F00 returns 0x0FF0 with rsp_id=1.
